uncached_dbus_bridge: RTL and testbench

Sits between the core's uncached data port and the memory-side request/response channel. Posts uncached stores into a small write buffer so they complete without stalling the core. Serves uncached loads strictly in program order after the buffer has drained. Returns load data to the core through the stall/rddata contract of the data bus.

---
 rtl/uncached_dbus_bridge_pkg.sv | 21 ++
 rtl/uncached_wbuf.sv | 52 +++++
 rtl/uncached_dbus_bridge.sv | 124 ++++++++++++
 tb/tb_uncached_dbus_bridge.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uncached_dbus_bridge_pkg.sv
// Shared types for the uncached data-bus bridge:
// write-buffer entry layout and load FSM states.
package uncached_dbus_bridge_pkg;

  localparam int UNCACHED_WBUF_DEPTH = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } uncached_wbuf_entry_t;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_DRAIN,
    RD_REQ,
    RD_RESP,
    RD_DONE
  } uncached_rd_state_t;

endpackage

// File: rtl/uncached_wbuf.sv
// Posted-store FIFO for the uncached bridge.
// Power-of-two depth; pointers wrap naturally.
module uncached_wbuf
  import uncached_dbus_bridge_pkg::*;
#(
  parameter int DEPTH = UNCACHED_WBUF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  uncached_wbuf_entry_t       push_data,
  input  logic                       pop,
  output uncached_wbuf_entry_t       head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 do_push;
  logic                 do_pop;
  uncached_wbuf_entry_t mem_q [DEPTH];

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push & ~do_pop)
        count <= count + 1'b1;
      else if (do_pop & ~do_push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uncached_dbus_bridge.sv
// Uncached data-bus bridge: posted stores via a write
// buffer, loads served in order once the buffer drains.
module uncached_dbus_bridge
  import uncached_dbus_bridge_pkg::*;
#(
  parameter int WBUF_DEPTH = UNCACHED_WBUF_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbus_read,
  input  logic        dbus_write,
  input  logic [31:0] dbus_address,
  input  logic [3:0]  dbus_byteenable,
  input  logic [31:0] dbus_wrdata,
  output logic        dbus_stall,
  output logic [31:0] dbus_rddata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wr,
  output logic [31:0] mem_req_addr,
  output logic [3:0]  mem_req_be,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata
);

  localparam int CW = $clog2(WBUF_DEPTH) + 1;

  uncached_rd_state_t   state;
  uncached_rd_state_t   state_nxt;
  uncached_wbuf_entry_t head;
  uncached_wbuf_entry_t push_data;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 st_issue;
  logic [CW-1:0]        count;

  // A full buffer refuses the store even if the head pops now.
  assign push      = dbus_write & ~full;
  assign push_data = '{addr: dbus_address,
                       be:   dbus_byteenable,
                       data: dbus_wrdata};
  assign st_issue  = ((state == RD_IDLE) | (state == RD_DRAIN))
                   & ~empty;
  assign pop       = st_issue & mem_req_ready;

  uncached_wbuf #(
    .DEPTH(WBUF_DEPTH)
  ) u_wbuf (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= RD_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RD_IDLE:
        if (dbus_read)
          state_nxt = (count != '0) ? RD_DRAIN : RD_REQ;
      RD_DRAIN:
        if (count == '0) state_nxt = RD_REQ;
      RD_REQ:
        if (mem_req_ready) state_nxt = RD_RESP;
      RD_RESP:
        if (mem_resp_valid) state_nxt = RD_DONE;
      RD_DONE:
        state_nxt = RD_IDLE;
      default:
        state_nxt = RD_IDLE;
    endcase
  end

  always_comb begin
    dbus_stall    = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_wr    = 1'b0;
    mem_req_addr  = '0;
    mem_req_be    = '0;
    mem_req_wdata = '0;
    unique case (1'b1)
      state == RD_IDLE:
        dbus_stall = dbus_read | (dbus_write & full);
      state == RD_DRAIN,
      state == RD_REQ,
      state == RD_RESP:
        dbus_stall = 1'b1;
      default:
        dbus_stall = 1'b0;
    endcase
    if (st_issue) begin
      mem_req_valid = 1'b1;
      mem_req_wr    = 1'b1;
      mem_req_addr  = head.addr;
      mem_req_be    = head.be;
      mem_req_wdata = head.data;
    end else if (state == RD_REQ) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = dbus_address;
      mem_req_be    = 4'hF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      dbus_rddata <= '0;
    else if ((state == RD_RESP) & mem_resp_valid)
      dbus_rddata <= mem_resp_rdata;
  end

endmodule

// File: tb/tb_uncached_dbus_bridge.sv
// Bench for uncached_dbus_bridge: reset vectors, directed
// corner cases and random traffic against an ordering model.
module tb_uncached_dbus_bridge;
  import uncached_dbus_bridge_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dbus_read = 1'b0;
  logic        dbus_write = 1'b0;
  logic [31:0] dbus_address = '0;
  logic [3:0]  dbus_byteenable = '0;
  logic [31:0] dbus_wrdata = '0;
  logic        dbus_stall;
  logic [31:0] dbus_rddata;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_wr;
  logic [31:0] mem_req_addr;
  logic [3:0]  mem_req_be;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = '0;

  always #5 clk = ~clk;

  uncached_dbus_bridge #(.WBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .dbus_read(dbus_read), .dbus_write(dbus_write),
    .dbus_address(dbus_address),
    .dbus_byteenable(dbus_byteenable),
    .dbus_wrdata(dbus_wrdata),
    .dbus_stall(dbus_stall), .dbus_rddata(dbus_rddata),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_wr(mem_req_wr), .mem_req_addr(mem_req_addr),
    .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    logic rd;
    logic wr;
    logic rdy;
    logic stall;
    logic valid;
  } vec_t;

  txn_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          model_cnt = 0;
  int          cnt_before = 0;
  int          hold_until = 0;
  bit          ready_rand = 0;
  int          min_delay = 0;
  int          max_delay = 0;
  bit          pend = 0;
  bit          new_hs = 0;
  bit          resp_fire = 0;
  int          resp_wait = 0;
  logic [31:0] resp_addr = '0;
  bit          prev_stuck = 0;
  logic        prev_wr;
  logic [31:0] prev_addr;
  logic [31:0] prev_wdata;
  logic [3:0]  prev_be;
  int          rd_hs = 0;
  int          first_hs_cyc = -1;
  logic        s_stall;
  logic        s_valid;
  logic        s_wr;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_be;
  logic [31:0] s_rddata;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h1FD0_0000) return 32'h1234_5678;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    txn_t t;
    if (prev_stuck) begin
      chk("hold_valid", 32'(mem_req_valid), 32'd1);
      chk("hold_wr", 32'(mem_req_wr), 32'(prev_wr));
      chk("hold_addr", mem_req_addr, prev_addr);
      chk("hold_be", 32'(mem_req_be), 32'(prev_be));
      chk("hold_wdata", mem_req_wdata, prev_wdata);
    end
    if (mem_req_valid && mem_req_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_req", 32'(mem_req_addr), 32'hFFFF_FFFF);
      end else begin
        t = exp_q.pop_front();
        chk("req_wr", 32'(mem_req_wr), 32'(t.wr));
        chk("req_addr", mem_req_addr, t.addr);
        chk("req_be", 32'(mem_req_be), 32'(t.be));
        if (t.wr) begin
          chk("req_wdata", mem_req_wdata, t.data);
          model_cnt--;
          if (first_hs_cyc < 0) first_hs_cyc = cyc;
        end else begin
          new_hs = 1;
          resp_addr = t.addr;
          rd_hs++;
        end
      end
    end
    prev_stuck = mem_req_valid && !mem_req_ready;
    prev_wr    = mem_req_wr;
    prev_addr  = mem_req_addr;
    prev_be    = mem_req_be;
    prev_wdata = mem_req_wdata;
    resp_fire  = mem_resp_valid;
  endtask

  task automatic tick();
    @(negedge clk);
    cnt_before = model_cnt;
    s_stall  = dbus_stall;
    s_rddata = dbus_rddata;
    s_valid  = mem_req_valid;
    s_wr     = mem_req_wr;
    s_addr   = mem_req_addr;
    s_be     = mem_req_be;
    s_wdata  = mem_req_wdata;
    if (!rst) monitor();
    else prev_stuck = 0;
    @(posedge clk);
    #1;
    cyc++;
    if (resp_fire) begin
      pend = 0;
      resp_fire = 0;
      mem_resp_valid = 1'b0;
    end
    if (new_hs) begin
      pend = 1;
      new_hs = 0;
      resp_wait = $urandom_range(max_delay, min_delay);
    end
    if (pend) begin
      if (resp_wait == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = mem_val(resp_addr);
      end else begin
        resp_wait--;
      end
    end
    if (rst || cyc < hold_until) mem_req_ready = 1'b0;
    else if (ready_rand) mem_req_ready = 1'($urandom_range(1, 0));
    else mem_req_ready = 1'b1;
  endtask

  task automatic idle(input int k);
    dbus_read = 1'b0;
    dbus_write = 1'b0;
    repeat (k) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dbus_read = 1'b0;
    dbus_write = 1'b0;
    mem_req_ready = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    pend = 0;
    new_hs = 0;
    resp_fire = 0;
    prev_stuck = 0;
    mem_resp_valid = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] d,
                          output int stalls, output int acc);
    txn_t t;
    dbus_read = 1'b0;
    dbus_write = 1'b1;
    dbus_address = a;
    dbus_byteenable = be;
    dbus_wrdata = d;
    stalls = 0;
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      chk("store_stall", 32'(s_stall), 32'(cnt_before == DEPTH));
      if (!s_stall) begin
        t = '{1'b1, a, be, d};
        exp_q.push_back(t);
        model_cnt++;
        acc = cyc - 1;
        break;
      end
      stalls++;
    end
    if (acc < 0) chk("store_timeout", 32'd0, 32'd1);
    dbus_write = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, output int n);
    txn_t t;
    bit   done;
    done = 0;
    t = '{1'b0, a, 4'hF, 32'h0};
    exp_q.push_back(t);
    dbus_write = 1'b0;
    dbus_read = 1'b1;
    dbus_address = a;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      n++;
      if (n == 1) chk("load_first_stall", 32'(s_stall), 32'd1);
      if (!s_stall) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("load_timeout", 32'd0, 32'd1);
    else chk("load_rddata", s_rddata, mem_val(a));
    dbus_read = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   st;
    int   acc;
    int   acc5;
    int   n;
    int   c0;
    int   hs0;
    int   r;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      dbus_read = vecs[i].rd;
      dbus_write = vecs[i].wr;
      dbus_address = 32'h1000_0040;
      dbus_byteenable = 4'h3;
      dbus_wrdata = 32'hCAFE_0000 + i;
      mem_req_ready = vecs[i].rdy;
      tick();
      chk("vec_stall", 32'(s_stall), 32'(vecs[i].stall));
      chk("vec_valid", 32'(s_valid), 32'(vecs[i].valid));
      chk("vec_rddata", s_rddata, 32'h0);
      chk("vec_req_zero", s_addr | s_wdata | 32'(s_be) | 32'(s_wr),
          32'h0);
    end

    // Single posted store, handshake the following cycle.
    do_reset();
    first_hs_cyc = -1;
    do_store(32'h1FAF_F000, 4'hF, 32'hDEAD_BEEF, st, acc);
    chk("single_store_stalls", st, 0);
    idle(3);
    chk("single_store_hs_cycle", first_hs_cyc, acc + 1);
    chk("single_store_drained", exp_q.size(), 0);

    // Five stores into a 4-deep buffer with ready held low.
    c0 = cyc;
    hold_until = c0 + 7;
    first_hs_cyc = -1;
    for (int i = 0; i < 4; i++) begin
      do_store(32'h2000_0000 + 32'(i * 4), 4'(i + 1),
               32'hA000_0000 + 32'(i), st, acc);
      chk("fill_no_stall", st, 0);
    end
    do_store(32'h2000_0010, 4'hC, 32'hA000_0004, st, acc5);
    chk("fifth_stalled", st, 4);
    chk("first_hs_cycle", first_hs_cyc, c0 + 7);
    chk("fifth_accept_cycle", acc5, first_hs_cyc + 1);
    idle(8);
    chk("five_drained", exp_q.size(), 0);
    hold_until = 0;

    // Minimum-latency load from an empty buffer.
    do_load(32'h1FD0_0000, n);
    chk("load_min_stall", n - 1, 3);
    chk("load_rddata_known", s_rddata, 32'h1234_5678);
    idle(1);
    chk("rddata_held", s_rddata, 32'h1234_5678);

    // Stores ahead of a load must reach memory first.
    do_store(32'h3000_0000, 4'hF, 32'h1111_1111, st, acc);
    do_store(32'h3000_0004, 4'h1, 32'h2222_2222, st, acc);
    do_load(32'h3000_0008, n);
    chk("wwr_slower", 32'((n - 1) > 3), 32'd1);
    idle(2);

    // Read request held off for four cycles in REQ.
    hs0 = rd_hs;
    hold_until = cyc + 5;
    do_load(32'h4000_0100, n);
    chk("req_wait_stall", n - 1, 7);
    chk("req_wait_one_hs", rd_hs - hs0, 1);
    hold_until = 0;
    idle(2);

    // Reset while draining three buffered stores.
    hold_until = cyc + 1000;
    for (int i = 0; i < 3; i++)
      do_store(32'h5000_0000 + 32'(i * 4), 4'hF, 32'(i), st, acc);
    dbus_read = 1'b1;
    dbus_address = 32'h5000_1000;
    tick();
    tick();
    chk("drain_stall", 32'(s_stall), 32'd1);
    hold_until = 0;
    do_reset();
    tick();
    chk("rst_drain_stall", 32'(s_stall), 32'd0);
    chk("rst_drain_valid", 32'(s_valid), 32'd0);
    do_load(32'h6000_0000, n);
    chk("rst_drain_empty", n - 1, 3);

    // Reset while waiting for a read response.
    min_delay = 5;
    max_delay = 5;
    do_load(32'h6000_0004, n);
    exp_q.push_back('{1'b0, 32'h6000_0008, 4'hF, 32'h0});
    dbus_read = 1'b1;
    dbus_address = 32'h6000_0008;
    tick();
    tick();
    tick();
    chk("resp_wait_stall", 32'(s_stall), 32'd1);
    do_reset();
    min_delay = 0;
    max_delay = 0;
    tick();
    chk("rst_resp_stall", 32'(s_stall), 32'd0);
    chk("rst_resp_valid", 32'(s_valid), 32'd0);
    chk("rst_resp_rddata", s_rddata, 32'h0);

    // Random traffic against the in-order model.
    ready_rand = 1;
    max_delay = 2;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(9, 0);
      if (r < 5)
        do_store($urandom, 4'($urandom_range(15, 1)), $urandom,
                 st, acc);
      else if (r < 8)
        do_load($urandom, n);
      else
        idle($urandom_range(2, 1));
    end
    ready_rand = 0;
    idle(12);
    chk("random_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
